// File: rtl/spi_flash_pkg.sv
// spi_flash_pkg: shared types and constants for the EN25F80 read-only SPI
// flash controller.
//   state_t        controller FSM states
//   SPI_CMD_READ   serial flash READ opcode
//   SPI_XFER_BITS  bits per word fetch (opcode + address + data)
//   SPI_DATA_BITS  data bits per word fetch
//   read_word()    builds the 64-bit outgoing shift word for an address
//   byte_swap()    turns the received bit stream into a little-endian word
package spi_flash_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        DONE,
        RECOVER
    } state_t;

    localparam logic [7:0] SPI_CMD_READ  = 8'h03;
    localparam int         SPI_XFER_BITS = 64;
    localparam int         SPI_DATA_BITS = 32;

    // Opcode, 24-bit byte address (word aligned, 1 MiB part), then 32 dummy
    // bits clocked out while the data word comes back.
    function automatic logic [SPI_XFER_BITS-1:0] read_word(input logic [31:0] addr);
        return {SPI_CMD_READ, 4'h0, addr[19:2], 2'b00, 32'h0};
    endfunction

    // The first received byte sits in the top byte of the stream; it must
    // land in the least significant byte of the word.
    function automatic logic [SPI_DATA_BITS-1:0] byte_swap(input logic [SPI_DATA_BITS-1:0] rx);
        return {rx[7:0], rx[15:8], rx[23:16], rx[31:24]};
    endfunction

endpackage

// File: rtl/spi_flash_ctrl.sv
// spi_flash_ctrl: read-only SPI master (mode 0) serving devctrl's flash port.
// Each request fetches one 32-bit word from the EN25F80 with a single READ
// (0x03) transaction and presents it little-endian.
// Ports:
//   clk, rst_n          system clock, asynchronous active-low reset
//   devEnable_i         flash selected by devctrl
//   readEnable_i        access is a read (writes are ignored)
//   addr_i              byte address, only [19:2] used
//   readData_o          fetched word, held until the next completed fetch
//   busy_o              request present and not yet satisfied
//   spi_clk_o           SPI clock, idles low
//   spi_cs_n_o          chip select, active low
//   spi_di_o            MOSI
//   spi_do_i            MISO
module spi_flash_ctrl
    import spi_flash_pkg::*;
#(
    parameter int CLK_DIV = 1,
    parameter int CS_IDLE = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        devEnable_i,
    input  logic        readEnable_i,
    input  logic [31:0] addr_i,
    output logic [31:0] readData_o,
    output logic        busy_o,
    output logic        spi_clk_o,
    output logic        spi_cs_n_o,
    output logic        spi_di_o,
    input  logic        spi_do_i
);

    localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);
    localparam logic [3:0] REC_LAST = 4'(CS_IDLE - 1);
    localparam logic [5:0] BIT_LAST = 6'(SPI_XFER_BITS - 1);

    state_t                     state, state_nx;
    logic [3:0]                 phase_cnt;
    logic [5:0]                 bit_cnt;
    logic [SPI_XFER_BITS-1:0]   shift_q;
    logic [SPI_XFER_BITS-1:0]   cmd_word;
    logic                       req;
    logic                       tick;
    logic                       bit_end;
    logic                       in_xfer_nx;
    logic                       unused_addr;

    assign req      = devEnable_i & readEnable_i;
    assign busy_o   = req & (state != DONE);
    assign cmd_word = read_word(addr_i);
    // Last clk cycle of the current SPI half-period.
    assign tick     = (phase_cnt == DIV_LAST);
    // End of a high phase: sample MISO, shift, advance the bit.
    assign bit_end  = (state == SHIFT) & tick & spi_clk_o;
    assign unused_addr = ^{addr_i[31:20], addr_i[1:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (req)                            state_nx = SETUP;
            SETUP:   if (tick)                           state_nx = SHIFT;
            SHIFT:   if (bit_end && bit_cnt == BIT_LAST) state_nx = HOLD;
            HOLD:    if (tick)                           state_nx = DONE;
            DONE:    if (!req)                           state_nx = RECOVER;
            RECOVER: if (phase_cnt == REC_LAST)          state_nx = IDLE;
            default:                                     state_nx = IDLE;
        endcase
    end

    assign in_xfer_nx = (state_nx == SETUP) | (state_nx == SHIFT) | (state_nx == HOLD);

    // SPI pins are driven from flops computed one cycle ahead, so they are
    // glitch-free and line up with the state they belong to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_cnt  <= '0;
            bit_cnt    <= '0;
            shift_q    <= '0;
            spi_clk_o  <= 1'b0;
            spi_cs_n_o <= 1'b1;
            spi_di_o   <= 1'b0;
            readData_o <= '0;
        end else begin
            spi_cs_n_o <= ~in_xfer_nx;

            if (state_nx != state)
                phase_cnt <= '0;
            else if (state == RECOVER ||
                     ((state == SETUP || state == SHIFT || state == HOLD) && !tick))
                phase_cnt <= phase_cnt + 4'd1;
            else
                phase_cnt <= '0;

            if (state == SHIFT && tick) spi_clk_o <= ~spi_clk_o;
            else if (state != SHIFT)    spi_clk_o <= 1'b0;

            if (state == IDLE && req) begin
                shift_q  <= cmd_word;
                spi_di_o <= cmd_word[SPI_XFER_BITS-1];
            end else if (bit_end) begin
                // The whole stream shifts through; after 64 bits the low
                // half holds exactly the 32 data bits.
                shift_q  <= {shift_q[SPI_XFER_BITS-2:0], spi_do_i};
                spi_di_o <= (bit_cnt == BIT_LAST) ? 1'b0 : shift_q[SPI_XFER_BITS-2];
                bit_cnt  <= bit_cnt + 6'd1;
            end

            // A request that went away mid-transfer never publishes its data.
            if (state == HOLD && tick && req)
                readData_o <= byte_swap(shift_q[SPI_DATA_BITS-1:0]);
        end
    end

endmodule
